// File: rtl/dma_ram_to_fir_pkg.sv
`default_nettype none
// ============================================================================
// dma_ram_to_fir_pkg : register map, FSM states and STATUS bit positions
// Revision 1.0 - initial release
// ============================================================================
package dma_ram_to_fir_pkg;

  localparam logic [3:0] OFF_SRC    = 4'h0;
  localparam logic [3:0] OFF_LEN    = 4'h4;
  localparam logic [3:0] OFF_CTRL   = 4'h8;
  localparam logic [3:0] OFF_STATUS = 4'hC;

  localparam int STATUS_BUSY = 0;
  localparam int STATUS_DONE = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/dma_ram_to_fir_if.sv
`default_nettype none
// ============================================================================
// dma_ram_to_fir_if : single-beat Wishbone link (dat_w master->slave, dat_r back)
// Revision 1.0 - initial release
// ============================================================================
interface dma_ram_to_fir_if;

  logic        stb;
  logic        cyc;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;

  modport master (output stb, cyc, we, sel, adr, dat_w, input  dat_r, ack);
  modport slave  (input  stb, cyc, we, sel, adr, dat_w, output dat_r, ack);

endinterface
`default_nettype wire

// File: rtl/dma_ram_to_fir_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo : first-word-fall-through synchronous FIFO, power-of-two depth
// Revision 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     push_i,
  input  wire logic                     pop_i,
  input  wire logic [WIDTH-1:0]         din_i,
  output      logic [WIDTH-1:0]         dout_o,
  output      logic                     full_o,
  output      logic                     empty_o,
  output      logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/dma_ram_to_fir.sv
`default_nettype none
// ============================================================================
// dma_ram_to_fir : CPU-programmed DMA streaming RAM words into the FIR X input
// Revision 1.0 - initial release
// ============================================================================
module dma_ram_to_fir
  import dma_ram_to_fir_pkg::*;
#(
  parameter logic [31:0] REG_BASE   = 32'h300000A0,
  parameter logic [31:0] FIR_X_ADDR = 32'h30000080,
  parameter int          LEN_W      = 16,
  parameter int          FIFO_DEPTH = 4
) (
  input wire logic          clk,
  input wire logic          rst,
  dma_ram_to_fir_if.slave   wbs,
  dma_ram_to_fir_if.master  ram,
  dma_ram_to_fir_if.master  fir
);

  localparam int                CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_e           state_q;
  logic [31:0]      src_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] rd_cnt_q;
  logic [LEN_W-1:0] wr_cnt_q;
  logic             done_q;

  logic [31:0]      w_off;
  logic             w_hit;
  logic             w_busy;
  logic             w_cfg_wr;
  logic             w_start;
  logic [31:0]      w_status;
  logic [31:0]      w_rdata;
  logic             w_ram_ack;
  logic             w_fir_ack;
  logic             w_rd_issue;
  logic             w_wr_issue;

  logic [31:0]      fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             w_unused;

  // Ack is held off while high so a master that keeps stb asserted gets one pulse.
  assign w_off    = wbs.adr - REG_BASE;
  assign w_hit    = wbs.stb & wbs.cyc & ~wbs.ack & (w_off[31:4] == '0) & (w_off[1:0] == 2'b00);
  assign w_busy   = (state_q == ST_RUN);
  assign w_cfg_wr = w_hit & wbs.we & ~w_busy;
  assign w_start  = w_cfg_wr & (w_off[3:0] == OFF_CTRL) & wbs.dat_w[0];

  assign w_ram_ack  = ram.stb & ram.ack;
  assign w_fir_ack  = fir.stb & fir.ack;
  assign w_rd_issue = w_busy & ~ram.stb & (rd_cnt_q < len_q) & ~fifo_full;
  assign w_wr_issue = ~fir.stb & ~fifo_empty;

  assign w_unused = ^{wbs.sel, fir.dat_r, fifo_count, ram.dat_w};

  always_comb begin
    w_status              = '0;
    w_status[STATUS_BUSY] = w_busy;
    w_status[STATUS_DONE] = done_q;
  end

  always_comb begin
    w_rdata = '0;
    unique case (w_off[3:0])
      OFF_SRC:    w_rdata = src_q;
      OFF_LEN:    w_rdata = 32'(len_q);
      OFF_STATUS: w_rdata = w_status;
      default:    w_rdata = '0;
    endcase
  end

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_ram_ack),
    .pop_i   (w_fir_ack),
    .din_i   (ram.dat_r),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      src_q     <= '0;
      len_q     <= '0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      done_q    <= 1'b0;
      wbs.ack   <= 1'b0;
      wbs.dat_r <= '0;
    end else begin
      wbs.ack <= w_hit;
      if (w_hit) begin
        wbs.dat_r <= wbs.we ? '0 : w_rdata;
      end
      if (w_cfg_wr && (w_off[3:0] == OFF_SRC)) src_q <= {wbs.dat_w[31:2], 2'b00};
      if (w_cfg_wr && (w_off[3:0] == OFF_LEN)) len_q <= wbs.dat_w[LEN_W-1:0];
      if (w_ram_ack) rd_cnt_q <= rd_cnt_q + LEN_ONE;
      if (w_fir_ack) wr_cnt_q <= wr_cnt_q + LEN_ONE;

      unique case (state_q)
        ST_RUN: begin
          if (w_fir_ack && ((wr_cnt_q + LEN_ONE) == len_q)) begin
            state_q <= ST_DONE;
          end
        end
        default: begin
          // DONE lasts one cycle and latches the sticky flag on its way back to IDLE.
          if (state_q == ST_DONE) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
          if (w_start) begin
            done_q   <= 1'b0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            state_q  <= (len_q != '0) ? ST_RUN : ST_DONE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ram.stb   <= 1'b0;
      ram.cyc   <= 1'b0;
      ram.we    <= 1'b0;
      ram.sel   <= 4'h0;
      ram.adr   <= '0;
      ram.dat_w <= '0;
    end else begin
      ram.we    <= 1'b0;
      ram.dat_w <= '0;
      if (w_ram_ack) begin
        ram.stb <= 1'b0;
        ram.cyc <= 1'b0;
        ram.sel <= 4'h0;
        ram.adr <= '0;
      end else if (w_rd_issue) begin
        ram.stb <= 1'b1;
        ram.cyc <= 1'b1;
        ram.sel <= 4'hF;
        ram.adr <= src_q + (32'(rd_cnt_q) << 2);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fir.stb   <= 1'b0;
      fir.cyc   <= 1'b0;
      fir.we    <= 1'b0;
      fir.sel   <= 4'h0;
      fir.adr   <= '0;
      fir.dat_w <= '0;
    end else begin
      if (w_fir_ack) begin
        fir.stb   <= 1'b0;
        fir.cyc   <= 1'b0;
        fir.we    <= 1'b0;
        fir.sel   <= 4'h0;
        fir.adr   <= '0;
        fir.dat_w <= '0;
      end else if (w_wr_issue) begin
        fir.stb   <= 1'b1;
        fir.cyc   <= 1'b1;
        fir.we    <= 1'b1;
        fir.sel   <= 4'hF;
        fir.adr   <= FIR_X_ADDR;
        fir.dat_w <= fifo_dout;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dma_ram_to_fir.sv
`default_nettype none
// ============================================================================
// tb_dma_ram_to_fir : directed bench with RAM/FIR responders and a register table
// Revision 1.0 - initial release
// ============================================================================
module tb_dma_ram_to_fir;

  localparam logic [31:0] REG_BASE = 32'h300000A0;
  localparam logic [31:0] FIR_X    = 32'h30000080;
  localparam logic [31:0] A_SRC    = REG_BASE + 32'h0;
  localparam logic [31:0] A_LEN    = REG_BASE + 32'h4;
  localparam logic [31:0] A_CTRL   = REG_BASE + 32'h8;
  localparam logic [31:0] A_STAT   = REG_BASE + 32'hC;
  localparam int          NV       = 13;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic        exp_ack;
    logic [31:0] exp_rd;
  } vec_t;

  logic clk;
  logic rst;

  dma_ram_to_fir_if wbs ();
  dma_ram_to_fir_if ram ();
  dma_ram_to_fir_if fir ();

  dma_ram_to_fir #(
    .REG_BASE   (REG_BASE),
    .FIR_X_ADDR (FIR_X),
    .LEN_W      (16),
    .FIFO_DEPTH (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .wbs (wbs),
    .ram (ram),
    .fir (fir)
  );

  int          checks = 0;
  int          failures = 0;
  int          fir_lat = 0;
  int          fir_wait = 0;
  int          ram_stb_cyc, fir_stb_cyc, occ, occ_max, reads_at_first_wr, proto_err;
  logic [31:0] fir_hold;
  logic [31:0] ram_adr_log[$];
  logic [31:0] fir_dat_log[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ram_data(input logic [31:0] a);
    return 32'h11 * (32'(a[15:2]) + 32'd1);
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    ram_adr_log.delete();
    fir_dat_log.delete();
    ram_stb_cyc       = 0;
    fir_stb_cyc       = 0;
    occ               = 0;
    occ_max           = 0;
    reads_at_first_wr = -1;
    proto_err         = 0;
  endtask

  // RAM acks every request in one cycle; FIR acks after fir_lat wait cycles.
  initial begin
    ram.ack = 1'b0; ram.dat_r = '0; fir.ack = 1'b0; fir.dat_r = '0;
    forever begin
      @(negedge clk);
      ram.ack = 1'b0;
      fir.ack = 1'b0;
      if (ram.stb) begin
        ram_stb_cyc++;
        if (!ram.cyc || ram.we || ram.sel != 4'hF) proto_err++;
        ram.ack   = 1'b1;
        ram.dat_r = ram_data(ram.adr);
        ram_adr_log.push_back(ram.adr);
        occ++;
      end
      if (fir.stb) begin
        fir_stb_cyc++;
        if (!fir.cyc || !fir.we || fir.sel != 4'hF || fir.adr != FIR_X) proto_err++;
        if (fir_wait > 0 && fir.dat_w != fir_hold) proto_err++;
        fir_hold = fir.dat_w;
        if (fir_wait >= fir_lat) begin
          fir.ack = 1'b1;
          fir_dat_log.push_back(fir.dat_w);
          if (reads_at_first_wr < 0) reads_at_first_wr = ram_adr_log.size();
          fir_wait = 0;
          occ--;
        end else begin
          fir_wait++;
        end
      end else begin
        fir_wait = 0;
      end
      if (occ > occ_max) occ_max = occ;
    end
  end

  task automatic cpu_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input int maxw, output logic got, output logic [31:0] rd);
    got = 1'b0;
    rd  = '0;
    @(negedge clk);
    wbs.stb = 1'b1; wbs.cyc = 1'b1; wbs.we = we; wbs.adr = adr; wbs.dat_w = dat; wbs.sel = 4'hF;
    for (int i = 0; i < maxw && !got; i++) begin
      @(negedge clk);
      if (wbs.ack) begin
        got = 1'b1;
        rd  = wbs.dat_r;
      end
    end
    wbs.stb = 1'b0; wbs.cyc = 1'b0; wbs.we = 1'b0;
    if (got) begin
      @(negedge clk);
      check32("ack_single_cycle", 32'(wbs.ack), 32'd0);
    end
  endtask

  task automatic cpu_wr(input string name, input logic [31:0] adr, input logic [31:0] dat);
    logic        got;
    logic [31:0] rd;
    cpu_access(1'b1, adr, dat, 8, got, rd);
    check32({name, "_ack"}, 32'(got), 32'd1);
  endtask

  task automatic cpu_rd(input string name, input logic [31:0] adr, input logic [31:0] exp);
    logic        got;
    logic [31:0] rd;
    cpu_access(1'b0, adr, 32'h0, 8, got, rd);
    check32({name, "_ack"}, 32'(got), 32'd1);
    check32(name, rd, exp);
  endtask

  task automatic wait_done(input string name);
    logic        got;
    logic [31:0] rd;
    logic        seen;
    seen = 1'b0;
    rd   = '0;
    for (int i = 0; i < 200 && !seen; i++) begin
      cpu_access(1'b0, A_STAT, 32'h0, 8, got, rd);
      if (got && rd[1]) seen = 1'b1;
    end
    check32({name, "_done_status"}, rd, 32'h2);
  endtask

  task automatic check_stream(input string name, input logic [31:0] src, input int len);
    check32({name, "_nreads"}, 32'(ram_adr_log.size()), 32'(len));
    check32({name, "_nwrites"}, 32'(fir_dat_log.size()), 32'(len));
    for (int k = 0; k < len && k < ram_adr_log.size(); k++)
      check32($sformatf("%s_rd_adr%0d", name, k), ram_adr_log[k], src + 32'(4 * k));
    for (int k = 0; k < len && k < fir_dat_log.size(); k++)
      check32($sformatf("%s_wr_dat%0d", name, k), fir_dat_log[k], ram_data(src + 32'(4 * k)));
    check32({name, "_protocol_errs"}, 32'(proto_err), 32'd0);
  endtask

  initial begin
    vec_t        vecs[NV];
    logic        got;
    logic [31:0] rd;
    int          guard;

    vecs[0]  = '{1'b1, A_SRC,          32'h38000001, 1'b1, 32'h0};
    vecs[1]  = '{1'b1, A_LEN,          32'h00000005, 1'b1, 32'h0};
    vecs[2]  = '{1'b0, A_SRC,          32'h0,        1'b1, 32'h38000000};
    vecs[3]  = '{1'b0, A_LEN,          32'h0,        1'b1, 32'h00000005};
    vecs[4]  = '{1'b0, A_STAT,         32'h0,        1'b1, 32'h00000000};
    vecs[5]  = '{1'b0, A_CTRL,         32'h0,        1'b1, 32'h00000000};
    vecs[6]  = '{1'b1, 32'h300000B0,   32'h1,        1'b0, 32'h0};
    vecs[7]  = '{1'b0, 32'h3000009C,   32'h0,        1'b0, 32'h0};
    vecs[8]  = '{1'b0, 32'h300000A2,   32'h0,        1'b0, 32'h0};
    vecs[9]  = '{1'b1, A_LEN,          32'hABCD1234, 1'b1, 32'h0};
    vecs[10] = '{1'b0, A_LEN,          32'h0,        1'b1, 32'h00001234};
    vecs[11] = '{1'b1, A_SRC,          32'hFFFFFFFF, 1'b1, 32'h0};
    vecs[12] = '{1'b0, A_SRC,          32'h0,        1'b1, 32'hFFFFFFFC};

    rst = 1'b1;
    wbs.stb = 1'b0; wbs.cyc = 1'b0; wbs.we = 1'b0; wbs.sel = 4'h0; wbs.adr = '0; wbs.dat_w = '0;
    clear_logs();
    repeat (3) @(negedge clk);
    check32("rst_wbs_ack",  32'(wbs.ack), 32'd0);
    check32("rst_wbs_dat",  wbs.dat_r, 32'd0);
    check32("rst_ram_ctrl", {29'd0, ram.stb, ram.cyc, ram.we}, 32'd0);
    check32("rst_ram_adr",  ram.adr, 32'd0);
    check32("rst_fir_ctrl", {28'd0, fir.stb, fir.cyc, fir.we, 1'b0} | 32'(fir.sel), 32'd0);
    check32("rst_fir_adr",  fir.adr, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      cpu_access(vecs[i].we, vecs[i].adr, vecs[i].wdat, 4, got, rd);
      check32($sformatf("vec%0d_ack", i), 32'(got), 32'(vecs[i].exp_ack));
      if (vecs[i].exp_ack && !vecs[i].we)
        check32($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
    end

    // LEN=0 start: no bus activity, done appears without busy.
    cpu_wr("len0_len", A_LEN, 32'h0);
    clear_logs();
    cpu_wr("len0_ctrl", A_CTRL, 32'h1);
    @(negedge clk);
    cpu_rd("len0_status", A_STAT, 32'h2);
    check32("len0_ram_stb_cycles", 32'(ram_stb_cyc), 32'd0);
    check32("len0_fir_stb_cycles", 32'(fir_stb_cyc), 32'd0);

    // Nominal 4-sample transfer with single-cycle FIR ack.
    fir_lat = 0;
    clear_logs();
    cpu_wr("nom_src", A_SRC, 32'h38000000);
    cpu_wr("nom_len", A_LEN, 32'd4);
    cpu_wr("nom_ctrl", A_CTRL, 32'h1);
    wait_done("nom");
    check_stream("nom", 32'h38000000, 4);

    // FIR back-pressure: reads must stop once the 4-entry buffer is full.
    fir_lat = 20;
    clear_logs();
    cpu_wr("bp_src", A_SRC, 32'h38000100);
    cpu_wr("bp_len", A_LEN, 32'd8);
    cpu_wr("bp_ctrl", A_CTRL, 32'h1);
    wait_done("bp");
    check32("bp_reads_before_first_write", 32'(reads_at_first_wr), 32'd4);
    check32("bp_max_occupancy", 32'(occ_max), 32'd4);
    check_stream("bp", 32'h38000100, 8);

    // Config writes while busy are acked but have no effect.
    fir_lat = 3;
    clear_logs();
    cpu_wr("busy_src", A_SRC, 32'h38000200);
    cpu_wr("busy_len", A_LEN, 32'd6);
    cpu_wr("busy_ctrl", A_CTRL, 32'h1);
    cpu_rd("busy_status_run", A_STAT, 32'h1);
    cpu_wr("busy_src_ignored", A_SRC, 32'h0);
    cpu_wr("busy_ctrl_ignored", A_CTRL, 32'h1);
    cpu_wr("busy_len_ignored", A_LEN, 32'd2);
    wait_done("busy");
    check_stream("busy", 32'h38000200, 6);
    cpu_rd("busy_src_kept", A_SRC, 32'h38000200);
    cpu_rd("busy_len_kept", A_LEN, 32'd6);

    // Reset in the middle of a 6-sample transfer, then a clean restart.
    fir_lat = 0;
    clear_logs();
    cpu_wr("mid_src", A_SRC, 32'h38000000);
    cpu_wr("mid_len", A_LEN, 32'd6);
    cpu_wr("mid_ctrl", A_CTRL, 32'h1);
    guard = 0;
    while (fir_dat_log.size() < 2 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check32("mid_two_samples_reached", 32'(fir_dat_log.size() >= 2), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check32("mid_rst_ram_stb", 32'(ram.stb), 32'd0);
    check32("mid_rst_fir_stb", 32'(fir.stb), 32'd0);
    check32("mid_rst_wbs_ack", 32'(wbs.ack), 32'd0);
    rst = 1'b0;
    cpu_rd("mid_rst_status", A_STAT, 32'h0);
    clear_logs();
    cpu_wr("re_src", A_SRC, 32'h38000040);
    cpu_wr("re_len", A_LEN, 32'd3);
    cpu_wr("re_ctrl", A_CTRL, 32'h1);
    wait_done("re");
    check_stream("re", 32'h38000040, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
